// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pipe_pkg;

  localparam int unsigned FWD_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } haz_state_t;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forward select: the MEM-stage result beats the WB-stage result.
module fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output fwd_sel_t          sel_o
);

  // Register 0 is never forwarded since it always reads as zero.
  always_comb begin
    sel_o = FWD_NONE;
    if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use
// stalls, memory-wait freezes and branch flushes.
// Optional feature macro: HAZARD_PERF_EN builds the stall/flush counters.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      mem_regwrite,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      wb_regwrite,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  input  logic                      branch_taken,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_bubble,
  output logic                      freeze,
  output logic [FLUSH_DEPTH-1:0]    flush,
  output logic [FWD_W*NUM_SRC-1:0]  fwd_sel,
  output logic [PERF_W-1:0]         stall_cycles,
  output logic [PERF_W-1:0]         flush_events
);

  haz_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_hit;
  logic             load_use;

  // One forward selector per EX-stage source operand.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel_t sel;
    fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
      .src_i          (ex_src[g*REG_AW +: REG_AW]),
      .mem_regwrite_i (mem_regwrite),
      .mem_rd_i       (mem_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_rd_i        (wb_rd),
      .sel_o          (sel)
    );
    assign fwd_sel[g*FWD_W +: FWD_W] = sel;
  end

  // Any used ID operand that matches the load destination in EX.
  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign load_use = id_valid && ex_memread && (ex_rd != '0) && src_hit;

  // State and stall-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and hazard outputs; memory freeze outranks branch, branch outranks load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    flush       = '0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          freeze     = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_d    = MEM_WAIT;
        end else if (branch_taken) begin
          flush = '1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_d = LU_STALL;
            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
          end
        end
      end
      LU_STALL: begin
        if (branch_taken) begin
          flush   = '1;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        if (mem_ack) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of PC-hold cycles and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (|flush)    flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (load latency 1 and 3) on shared
// inputs, checked every cycle against a behavioural model plus literal checks.
module tb_pipe_hazard_ctrl;

  localparam int NS = 2;
  localparam int AW = 5;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              id_valid, ex_memread, mem_regwrite, wb_regwrite;
  logic              mem_req, mem_ack, branch_taken;
  logic [NS*AW-1:0]  id_src, ex_src;
  logic [NS-1:0]     id_src_used;
  logic [AW-1:0]     ex_rd, mem_rd, wb_rd;

  logic              o1_pc, o1_ifid, o1_bub, o1_frz, o3_pc, o3_ifid, o3_bub, o3_frz;
  logic [FD-1:0]     o1_fl, o3_fl;
  logic [2*NS-1:0]   o1_fwd, o3_fwd;
  logic [31:0]       o1_sc, o1_fe, o3_sc, o3_fe;

  pipe_hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LATENCY(1), .FLUSH_DEPTH(FD)) u_d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_src(ex_src), .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .mem_req(mem_req),
    .mem_ack(mem_ack), .branch_taken(branch_taken), .pc_write(o1_pc), .ifid_write(o1_ifid),
    .idex_bubble(o1_bub), .freeze(o1_frz), .flush(o1_fl), .fwd_sel(o1_fwd),
    .stall_cycles(o1_sc), .flush_events(o1_fe));

  pipe_hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LATENCY(3), .FLUSH_DEPTH(FD)) u_d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_src(ex_src), .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .mem_req(mem_req),
    .mem_ack(mem_ack), .branch_taken(branch_taken), .pc_write(o3_pc), .ifid_write(o3_ifid),
    .idex_bubble(o3_bub), .freeze(o3_frz), .flush(o3_fl), .fwd_sel(o3_fwd),
    .stall_cycles(o3_sc), .flush_events(o3_fe));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [31:0] perf(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  // ---------------- behavioural model ----------------
  logic        a_pc[2], a_ifid[2], a_bub[2], a_frz[2];
  logic [1:0]  a_fl[2];
  logic [3:0]  a_fwd[2];
  logic [31:0] a_sc[2], a_fe[2];
  assign a_pc[0] = o1_pc;   assign a_pc[1] = o3_pc;
  assign a_ifid[0] = o1_ifid; assign a_ifid[1] = o3_ifid;
  assign a_bub[0] = o1_bub; assign a_bub[1] = o3_bub;
  assign a_frz[0] = o1_frz; assign a_frz[1] = o3_frz;
  assign a_fl[0] = o1_fl;   assign a_fl[1] = o3_fl;
  assign a_fwd[0] = o1_fwd; assign a_fwd[1] = o3_fwd;
  assign a_sc[0] = o1_sc;   assign a_sc[1] = o3_sc;
  assign a_fe[0] = o1_fe;   assign a_fe[1] = o3_fe;

  int lat[2] = '{1, 3};
  int m_rem[2];   // stall cycles still owed after the detecting cycle
  bit m_wait[2];  // waiting for memory acknowledge
  int m_sc[2], m_fe[2];

  function automatic logic [3:0] exp_fwd();
    logic [3:0] r;
    logic [4:0] s;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      s = ex_src[i*AW +: AW];
      if (mem_regwrite && mem_rd != 0 && mem_rd == s) r[2*i +: 2] = 2'b10;
      else if (wb_regwrite && wb_rd != 0 && wb_rd == s) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit exp_lu();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (id_src_used[i] && id_src[i*AW +: AW] == ex_rd) hit = 1'b1;
    return id_valid && ex_memread && (ex_rd != 0) && hit;
  endfunction

  // Compare both instances against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_rem[d] = 0; m_wait[d] = 1'b0; m_sc[d] = 0; m_fe[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit e_pc, e_ifid, e_bub, e_frz, e_fl, n_wait;
        int n_rem;
        e_pc = 1; e_ifid = 1; e_bub = 0; e_frz = 0; e_fl = 0;
        n_rem = m_rem[d]; n_wait = m_wait[d];
        if (m_wait[d]) begin
          e_frz = 1; e_pc = 0; e_ifid = 0; n_wait = !mem_ack;
        end else if (m_rem[d] > 0) begin
          if (branch_taken) begin e_fl = 1; n_rem = 0; end
          else begin e_pc = 0; e_ifid = 0; e_bub = 1; n_rem = m_rem[d] - 1; end
        end else if (mem_req && !mem_ack) begin
          e_frz = 1; e_pc = 0; e_ifid = 0; n_wait = 1;
        end else if (branch_taken) begin
          e_fl = 1;
        end else if (exp_lu()) begin
          e_pc = 0; e_ifid = 0; e_bub = 1; n_rem = lat[d] - 1;
        end
        chk($sformatf("L%0d pc_write", lat[d]), 32'(a_pc[d]), 32'(e_pc));
        chk($sformatf("L%0d ifid_write", lat[d]), 32'(a_ifid[d]), 32'(e_ifid));
        chk($sformatf("L%0d idex_bubble", lat[d]), 32'(a_bub[d]), 32'(e_bub));
        chk($sformatf("L%0d freeze", lat[d]), 32'(a_frz[d]), 32'(e_frz));
        chk($sformatf("L%0d flush", lat[d]), 32'(a_fl[d]), e_fl ? 32'h3 : 32'h0);
        chk($sformatf("L%0d fwd_sel", lat[d]), 32'(a_fwd[d]), 32'(exp_fwd()));
        chk($sformatf("L%0d stall_cycles", lat[d]), a_sc[d], perf(m_sc[d]));
        chk($sformatf("L%0d flush_events", lat[d]), a_fe[d], perf(m_fe[d]));
        m_rem[d] = n_rem; m_wait[d] = n_wait;
        if (!e_pc) m_sc[d]++;
        if (e_fl) m_fe[d]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); @(negedge clk); #1; endtask

  task automatic clear();
    id_valid = 0; id_src = '0; id_src_used = '0; ex_src = '0; ex_memread = 0; ex_rd = '0;
    mem_regwrite = 0; mem_rd = '0; wb_regwrite = 0; wb_rd = '0;
    mem_req = 0; mem_ack = 0; branch_taken = 0;
  endtask

  task automatic set_id(input int i, input logic [AW-1:0] r); id_src[i*AW +: AW] = r; endtask
  task automatic set_ex(input int i, input logic [AW-1:0] r); ex_src[i*AW +: AW] = r; endtask

  task automatic load_use_hazard();
    id_valid = 1; set_id(0, 5'd3); set_id(1, 5'd8); id_src_used = 2'b11;
    ex_memread = 1; ex_rd = 5'd8;
  endtask

  initial begin
    clear();
    #2;
    chk("reset pc_write", 32'(o3_pc), 32'd1);
    chk("reset ifid_write", 32'(o3_ifid), 32'd1);
    chk("reset idex_bubble", 32'(o1_bub), 32'd0);
    chk("reset freeze", 32'(o3_frz), 32'd0);
    chk("reset flush", 32'(o1_fl), 32'd0);
    chk("reset fwd_sel", 32'(o1_fwd), 32'd0);
    chk("reset stall_cycles", o3_sc, 32'd0);
    chk("reset flush_events", o3_fe, 32'd0);
    tick();
    rst = 0;

    // forwarding priority
    set_ex(0, 5'd5); set_ex(1, 5'd9);
    mem_regwrite = 1; mem_rd = 5'd5; wb_regwrite = 1; wb_rd = 5'd5;
    settle();
    chk("fwd mem beats wb", 32'(o1_fwd[1:0]), 32'h2);
    chk("fwd op1 none", 32'(o1_fwd[3:2]), 32'h0);
    tick(); mem_rd = 5'd0; settle();
    chk("fwd wb when mem_rd=0", 32'(o1_fwd[1:0]), 32'h1);
    tick(); wb_rd = 5'd9; settle();
    chk("fwd op1 wb only", 32'(o3_fwd), 32'h4);
    tick(); clear();

    // load-use, latency 1 vs 3
    load_use_hazard(); settle();
    chk("lu L1 pc_write c0", 32'(o1_pc), 32'd0);
    chk("lu L1 bubble c0", 32'(o1_bub), 32'd1);
    chk("lu L3 pc_write c0", 32'(o3_pc), 32'd0);
    tick(); ex_memread = 0; ex_rd = '0; mem_regwrite = 1; mem_rd = 5'd8; settle();
    chk("lu L1 pc_write c1", 32'(o1_pc), 32'd1);
    chk("lu L1 bubble c1", 32'(o1_bub), 32'd0);
    chk("lu L3 pc_write c1", 32'(o3_pc), 32'd0);
    tick(); settle();
    chk("lu L3 pc_write c2", 32'(o3_pc), 32'd0);
    tick(); set_ex(1, 5'd8); settle();
    chk("lu L3 pc_write c3", 32'(o3_pc), 32'd1);
    chk("lu L3 fwd after stall", 32'(o3_fwd[3:2]), 32'h2);
    chk("lu L3 stall_cycles", o3_sc, perf(3));
    chk("lu L1 stall_cycles", o1_sc, perf(1));
    tick(); clear();

    // no stall when operand unused or ex_rd is zero
    id_valid = 1; set_id(0, 5'd3); set_id(1, 5'd8); id_src_used = 2'b01;
    ex_memread = 1; ex_rd = 5'd8; settle();
    chk("unused operand no stall", 32'(o3_pc), 32'd1);
    tick(); id_src_used = 2'b11; set_id(1, 5'd0); ex_rd = 5'd0; settle();
    chk("ex_rd zero no stall", 32'(o3_pc), 32'd1);
    chk("ex_rd zero no bubble", 32'(o3_bub), 32'd0);
    tick(); clear();

    // branch aborts an LU stall
    load_use_hazard(); settle();
    tick(); clear(); branch_taken = 1; settle();
    chk("abort flush", 32'(o3_fl), 32'h3);
    chk("abort pc_write", 32'(o3_pc), 32'd1);
    tick(); branch_taken = 0; settle();
    chk("abort back in run", 32'(o3_pc), 32'd1);
    chk("abort flush clear", 32'(o3_fl), 32'h0);
    chk("abort flush_events", o3_fe, perf(1));
    tick(); clear();

    // memory wait: ack arrives on the fifth cycle
    mem_req = 1;
    for (int k = 0; k < 5; k++) begin
      mem_ack = (k == 4);
      branch_taken = (k == 2);
      settle();
      chk($sformatf("mem wait freeze k%0d", k), 32'(o3_frz), 32'd1);
      if (k == 2) chk("mem wait branch ignored", 32'(o1_fl), 32'h0);
      tick();
    end
    clear(); settle();
    chk("mem wait released", 32'(o3_frz), 32'd0);
    tick();

    // req and ack together: no freeze
    mem_req = 1; mem_ack = 1; settle();
    chk("req+ack no freeze", 32'(o1_frz), 32'd0);
    chk("req+ack pc_write", 32'(o1_pc), 32'd1);
    tick(); clear();

    // branch and load-use together: flush wins
    load_use_hazard(); branch_taken = 1; settle();
    chk("br+lu flush", 32'(o3_fl), 32'h3);
    chk("br+lu pc_write", 32'(o3_pc), 32'd1);
    chk("br+lu no bubble", 32'(o3_bub), 32'd0);
    tick(); clear(); settle();
    chk("br+lu no stall after", 32'(o3_pc), 32'd1);
    tick();

    // asynchronous reset in the middle of a stall
    load_use_hazard(); settle();
    tick(); clear(); settle();
    chk("pre-reset stalled", 32'(o3_pc), 32'd0);
    #1 rst = 1; #1;
    chk("async reset pc_write", 32'(o3_pc), 32'd1);
    chk("async reset bubble", 32'(o3_bub), 32'd0);
    chk("async reset stall_cycles", o3_sc, 32'd0);
    tick(); settle(); tick();
    rst = 0;

    // pseudo-random traffic, checked by the model every cycle
    for (int n = 0; n < 300; n++) begin
      id_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++) begin
        set_id(i, 5'($urandom_range(0, 3)));
        set_ex(i, 5'($urandom_range(0, 3)));
      end
      id_src_used  = 2'($urandom_range(0, 3));
      ex_memread   = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_regwrite  = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 3));
      mem_req      = ($urandom_range(0, 5) == 0);
      mem_ack      = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      tick();
    end
    clear(); settle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
